// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS-subset core: Moore strobes per state,
// a retired-instruction counter and a sticky halt on an unknown opcode.
module multi_cycle_control #(
  parameter logic [5:0] OP_R    = 6'b000000,
  parameter logic [5:0] OP_LW   = 6'b100011,
  parameter logic [5:0] OP_SW   = 6'b101011,
  parameter logic [5:0] OP_BEQ  = 6'b000100,
  parameter logic [5:0] OP_J    = 6'b000010,
  parameter logic [5:0] OP_ADDI = 6'b001000
) (
  input  logic        MCLK,
  input  logic        MRST,
  input  logic [5:0]  Op,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        PCEn,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  State,
  output logic        Halted,
  output logic [15:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        retire;
  logic        branch;

  always_ff @(posedge MCLK) begin
    if (!MRST) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (Op == OP_LW || Op == OP_SW) state_d = S_MEMADR;
        else if (Op == OP_R)            state_d = S_EXEC;
        else if (Op == OP_BEQ)          state_d = S_BRANCH;
        else if (Op == OP_J)            state_d = S_JUMP;
        else if (Op == OP_ADDI)         state_d = S_ADDIEX;
        else                            state_d = S_HALT;
      end
      // IR still holds the opcode, so LW/SW is resolved again here.
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
      default: retire = 1'b0;
    endcase
    instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    branch   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: ;
    endcase
    // In reset the datapath sees idle FETCH selects with every write disabled.
    if (!MRST) begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      ALUSrcA  = 1'b0;
      PCSrc    = 2'b00;
      ALUSrcB  = 2'b01;
      ALUOp    = 2'b00;
      branch   = 1'b0;
    end
    PCEn = PCWrite | (branch & Zero);
  end

  assign State      = state_q;
  assign Halted     = (state_q == S_HALT);
  assign InstrCount = instr_count_q;

endmodule
